// File: rtl/data_mem_ctrl.sv
// Data-memory responder for the simd_processor M-stage port, with a host
// load/run/dump sequencer. Ports follow the processor and host signal names.
//
// Ports:
//   clk, reset           clock, async active-high reset
//   memwriteM, src_sel   processor store strobe, bank select (0 in, 1 out)
//   aluoutM, writedataM  processor byte address and store data
//   readdataM            processor load data (combinational, RUN only)
//   cpu_reset            processor reset, low only in RUN
//   host_start, host_len start a sequence, word count to load/dump
//   host_wvalid/wdata/wready  load stream into bank 0
//   host_rvalid/rdata/rready  dump stream out of bank 1
//   host_done            sequence complete
module data_mem_ctrl #(
  parameter int AW        = 10,
  parameter int HALT_ADDR = (1 << AW) - 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwriteM,
  input  logic          src_sel,
  input  logic [31:0]   aluoutM,
  input  logic [31:0]   writedataM,
  output logic [31:0]   readdataM,
  output logic          cpu_reset,
  input  logic          host_start,
  input  logic [AW:0]   host_len,
  input  logic          host_wvalid,
  input  logic [31:0]   host_wdata,
  output logic          host_wready,
  output logic          host_rvalid,
  output logic [31:0]   host_rdata,
  input  logic          host_rready,
  output logic          host_done
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] HALT_IDX = AW'(HALT_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DUMP,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [AW:0]   r_len;
  logic [AW:0]   r_load_ptr;
  logic [AW:0]   r_dump_ptr;
  logic          r_cpu_reset;
  logic          r_wready;
  logic          r_rvalid;
  logic          r_done;

  // Not reset: contents survive reset and later sequences.
  logic [31:0]   r_bank0 [DEPTH];
  logic [31:0]   r_bank1 [DEPTH];

  logic [AW-1:0] w_idx;
  logic [AW:0]   w_len_m1;
  logic          w_load_hs;
  logic          w_dump_hs;
  logic          w_cpu_wr;
  logic          w_halt;
  logic          w_unused;

  // Byte offset and high address bits alias onto the same word.
  assign w_idx    = aluoutM[AW+1:2];
  assign w_unused = ^{aluoutM[31:AW+2], aluoutM[1:0]};
  assign w_len_m1 = r_len - 1'b1;

  assign w_load_hs = (r_state == S_LOAD) && r_wready && host_wvalid;
  assign w_dump_hs = (r_state == S_DUMP) && r_rvalid && host_rready;
  assign w_cpu_wr  = (r_state == S_RUN) && memwriteM;
  assign w_halt    = w_cpu_wr && src_sel && (w_idx == HALT_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_load_ptr  <= '0;
      r_dump_ptr  <= '0;
      r_cpu_reset <= 1'b1;
      r_wready    <= 1'b0;
      r_rvalid    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (host_start) begin
            r_len      <= host_len;
            r_load_ptr <= '0;
            r_dump_ptr <= '0;
            r_done     <= 1'b0;
            if (host_len == '0) begin
              r_state     <= S_RUN;
              r_cpu_reset <= 1'b0;
            end else begin
              r_state  <= S_LOAD;
              r_wready <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (w_load_hs) begin
            r_load_ptr <= r_load_ptr + 1'b1;
            if (r_load_ptr == w_len_m1) begin
              r_state     <= S_RUN;
              r_wready    <= 1'b0;
              r_cpu_reset <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (w_halt) begin
            r_state     <= S_DUMP;
            r_cpu_reset <= 1'b1;
            // Empty dump never presents a word.
            r_rvalid    <= (r_len != '0);
          end
        end
        S_DUMP: begin
          if (r_len == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (w_dump_hs) begin
            r_dump_ptr <= r_dump_ptr + 1'b1;
            if (r_dump_ptr == w_len_m1) begin
              r_state  <= S_DONE;
              r_rvalid <= 1'b0;
              r_done   <= 1'b1;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_cpu_reset <= 1'b1;
          r_wready    <= 1'b0;
          r_rvalid    <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  // Load stream and processor stores to bank 0 are never active together.
  always_ff @(posedge clk) begin
    if (w_load_hs) begin
      r_bank0[r_load_ptr[AW-1:0]] <= host_wdata;
    end else if (w_cpu_wr && !src_sel) begin
      r_bank0[w_idx] <= writedataM;
    end
    if (w_cpu_wr && src_sel) begin
      r_bank1[w_idx] <= writedataM;
    end
  end

  // Asynchronous read: a same-cycle store is seen only after its edge.
  always_comb begin
    readdataM = '0;
    if (r_state == S_RUN) begin
      readdataM = src_sel ? r_bank1[w_idx] : r_bank0[w_idx];
    end
  end

  assign host_rdata  = r_bank1[r_dump_ptr[AW-1:0]];
  assign cpu_reset   = r_cpu_reset;
  assign host_wready = r_wready;
  assign host_rvalid = r_rvalid;
  assign host_done   = r_done;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed load/run/dump sequences
// with random data, compared against plain word arrays.
module tb_data_mem_ctrl;

  localparam int AW   = 10;
  localparam int HALT = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          memwriteM;
  logic          src_sel;
  logic [31:0]   aluoutM;
  logic [31:0]   writedataM;
  logic [31:0]   readdataM;
  logic          cpu_reset;
  logic          host_start;
  logic [AW:0]   host_len;
  logic          host_wvalid;
  logic [31:0]   host_wdata;
  logic          host_wready;
  logic          host_rvalid;
  logic [31:0]   host_rdata;
  logic          host_rready;
  logic          host_done;

  int total = 0;
  int bad   = 0;

  logic [31:0] m0 [1 << AW];
  logic [31:0] m1 [1 << AW];

  always #5 clk = ~clk;

  data_mem_ctrl #(.AW(AW), .HALT_ADDR(HALT)) dut (
    .clk(clk), .reset(reset),
    .memwriteM(memwriteM), .src_sel(src_sel),
    .aluoutM(aluoutM), .writedataM(writedataM),
    .readdataM(readdataM), .cpu_reset(cpu_reset),
    .host_start(host_start), .host_len(host_len),
    .host_wvalid(host_wvalid), .host_wdata(host_wdata),
    .host_wready(host_wready), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata), .host_rready(host_rready),
    .host_done(host_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Byte address for a word index with random aliasing bits.
  function automatic logic [31:0] alias_addr(input int idx);
    logic [31:0] r;
    r = $urandom & 32'hFFFF_F003;
    return r | (32'(idx) << 2);
  endfunction

  task automatic start(input int len);
    host_len   = (AW+1)'(len);
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
  endtask

  task automatic load_words(input int n, input logic [31:0] base);
    int acc = 0;
    int cyc = 0;
    while (acc < n && cyc < 100) begin
      host_wvalid = 1'($urandom_range(0, 1));
      host_wdata  = base + 32'(acc);
      #1;
      chk("load_wready", 32'(host_wready), 32'd1);
      chk("load_cpu_reset", 32'(cpu_reset), 32'd1);
      if (host_wvalid) begin
        m0[acc] = host_wdata;
        acc++;
      end
      tick();
      cyc++;
    end
    host_wvalid = 1'b0;
    if (acc < n) chk("load_timeout", 32'(acc), 32'(n));
    chk("load_end_wready", 32'(host_wready), 32'd0);
    chk("run_cpu_reset", 32'(cpu_reset), 32'd0);
  endtask

  task automatic cpu_store(input logic sel, input int idx,
                           input logic [31:0] d);
    memwriteM  = 1'b1;
    src_sel    = sel;
    aluoutM    = alias_addr(idx);
    writedataM = d;
    if (sel) m1[idx] = d;
    else     m0[idx] = d;
    tick();
    memwriteM = 1'b0;
  endtask

  task automatic cpu_load(input string tag, input logic sel, input int idx);
    src_sel = sel;
    aluoutM = alias_addr(idx);
    #1;
    chk(tag, readdataM, sel ? m1[idx] : m0[idx]);
  endtask

  task automatic halt();
    memwriteM  = 1'b1;
    src_sel    = 1'b1;
    aluoutM    = 32'(HALT) << 2;
    writedataM = 32'h55;
    m1[HALT]   = 32'h55;
    #1;
    chk("halt_cycle_cpu_reset", 32'(cpu_reset), 32'd0);
    tick();
    memwriteM = 1'b0;
  endtask

  task automatic dump(input int n, input int stall);
    int got = 0;
    int cyc = 0;
    host_rready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      #1;
      chk("stall_rvalid", 32'(host_rvalid), 32'd1);
      chk("stall_rdata", host_rdata, m1[0]);
      tick();
    end
    while (got < n && cyc < 100) begin
      host_rready = 1'($urandom_range(0, 1));
      #1;
      chk("dump_rvalid", 32'(host_rvalid), 32'd1);
      chk("dump_rdata", host_rdata, m1[got]);
      chk("dump_not_done", 32'(host_done), 32'd0);
      if (host_rready) got++;
      tick();
      cyc++;
    end
    host_rready = 1'b0;
    if (got < n) chk("dump_timeout", 32'(got), 32'(n));
    chk("done_set", 32'(host_done), 32'd1);
    chk("done_rvalid", 32'(host_rvalid), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    reset = 1'b1;
    memwriteM = 1'b0; src_sel = 1'b0;
    aluoutM = '0; writedataM = '0;
    host_start = 1'b0; host_len = '0;
    host_wvalid = 1'b0; host_wdata = '0;
    host_rready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Asynchronous reset mid-cycle
    #2 reset = 1'b1;
    #1;
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_wready", 32'(host_wready), 32'd0);
    chk("rst_rvalid", 32'(host_rvalid), 32'd0);
    chk("rst_done", 32'(host_done), 32'd0);
    chk("rst_readdata", readdataM, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    aluoutM = 32'h8;
    tick();
    #1;
    chk("idle_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("idle_readdata", readdataM, 32'd0);
    @(negedge clk);

    // Load 4 words
    start(4);
    load_words(4, 32'hA0);
    src_sel = 1'b0;
    aluoutM = 32'h8;
    #1;
    chk("load_word2", readdataM, 32'hA2);
    @(negedge clk);

    // Store/load ordering and aliasing
    cpu_store(1'b1, 4, 32'h1111_1111);
    cpu_load("store_visible", 1'b1, 4);
    @(negedge clk);
    memwriteM  = 1'b1;
    src_sel    = 1'b1;
    aluoutM    = 32'h10;
    writedataM = 32'hDEAD_BEEF;
    #1;
    chk("same_cycle_old", readdataM, 32'h1111_1111);
    m1[4] = 32'hDEAD_BEEF;
    tick();
    memwriteM = 1'b0;
    aluoutM = 32'h10;
    #1;
    chk("next_cycle_new", readdataM, 32'hDEAD_BEEF);
    aluoutM = 32'h10 + (32'd4 << AW);
    #1;
    chk("alias_word", readdataM, 32'hDEAD_BEEF);
    @(negedge clk);

    // Random traffic on both banks
    for (int i = 0; i < 4; i++) cpu_store(1'b1, i, $urandom);
    for (int i = 4; i < 8; i++) cpu_store(1'b0, i, $urandom);
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1) cpu_load("rand_b1", 1'b1, $urandom_range(0, 4));
      else cpu_load("rand_b0", 1'b0, $urandom_range(0, 7));
      @(negedge clk);
    end

    // Halt, suppressed follow-up store, dump with backpressure
    halt();
    memwriteM  = 1'b1;
    src_sel    = 1'b1;
    aluoutM    = 32'h0;
    writedataM = 32'hBAD0_BAD0;
    #1;
    chk("post_halt_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("post_halt_readdata", readdataM, 32'd0);
    tick();
    memwriteM = 1'b0;
    dump(4, 2);

    // Zero-length sequence
    start(0);
    chk("zl_wready", 32'(host_wready), 32'd0);
    chk("zl_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("zl_done_drop", 32'(host_done), 32'd0);
    cpu_load("zl_keep_b1", 1'b1, 4);
    @(negedge clk);
    halt();
    chk("zl_dump_rvalid", 32'(host_rvalid), 32'd0);
    chk("zl_dump_cpu_reset", 32'(cpu_reset), 32'd1);
    tick();
    chk("zl_done", 32'(host_done), 32'd1);
    chk("zl_done_rvalid", 32'(host_rvalid), 32'd0);

    // Abort during dump, then restart
    start(4);
    load_words(4, 32'hC0);
    halt();
    host_rready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("abort_rdata", host_rdata, m1[i]);
      tick();
    end
    #2 reset = 1'b1;
    #1;
    chk("abort_rvalid", 32'(host_rvalid), 32'd0);
    chk("abort_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("abort_done", 32'(host_done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    host_rready = 1'b0;
    tick();
    chk("abort_idle_rvalid", 32'(host_rvalid), 32'd0);

    start(1);
    load_words(1, 32'hE0);
    for (int i = 0; i < 4; i++) begin
      cpu_load("keep_b0", 1'b0, i);
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      cpu_load("keep_b1", 1'b1, i);
      @(negedge clk);
    end
    cpu_load("keep_halt", 1'b1, HALT);
    @(negedge clk);
    d = $urandom;
    cpu_store(1'b1, 0, d);
    halt();
    dump(1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
